// File: rtl/la_capture_core.sv
// Logic-analyser capture engine: circular sample buffer with pre-trigger window,
// per-channel level/edge trigger combined by AND/OR, and a 1-cycle read port.
module la_capture_core #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned TRIG_N = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TRIG_N-1:0] trig_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [TRIG_N-1:0] trig_mask_i,
  input  logic [TRIG_N-1:0] trig_edge_i,
  input  logic              trig_mode_i,
  input  logic [AW-1:0]     pretrig_i,
  output logic [1:0]        state_o,
  output logic              done_o,
  output logic [AW-1:0]     trig_addr_o,
  output logic [AW-1:0]     start_addr_o,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StWait = 2'd2,
    StPost = 2'd3
  } state_e;

  state_e              state_q;
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       cnt_q;
  logic [AW-1:0]       pretrig_q;
  logic [TRIG_N-1:0]   mask_q;
  logic [TRIG_N-1:0]   edge_q;
  logic                mode_q;
  logic [TRIG_N-1:0]   trig_q;
  logic                done_q;
  logic [AW-1:0]       trig_addr_q;
  logic [AW-1:0]       start_addr_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [TRIG_N-1:0]   hit;
  logic                fire;
  logic [AW-1:0]       remain;
  logic                wr_en;

  always_comb begin
    // Edge channels only hit when the previous sample was low.
    hit    = trig_i & ~(edge_q & trig_q);
    remain = {AW{1'b1}} - pretrig_q;
    wr_en  = (state_q != StIdle);
    if (mask_q == '0) begin
      fire = 1'b1;
    end else if (mode_q) begin
      fire = &(hit | ~mask_q);
    end else begin
      fire = |(hit & mask_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      pretrig_q    <= '0;
      mask_q       <= '0;
      edge_q       <= '0;
      mode_q       <= 1'b0;
      trig_q       <= '0;
      done_q       <= 1'b0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      trig_q     <= trig_i;
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        rd_data_q <= mem[rd_addr_i];
      end

      if (abort_i) begin
        state_q <= StIdle;
        done_q  <= 1'b0;
      end else if (arm_i) begin
        pretrig_q <= pretrig_i;
        mask_q    <= trig_mask_i;
        edge_q    <= trig_edge_i;
        mode_q    <= trig_mode_i;
        wr_ptr_q  <= '0;
        cnt_q     <= '0;
        done_q    <= 1'b0;
        state_q   <= (pretrig_i == '0) ? StWait : StFill;
      end else begin
        if (wr_en) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        unique case (state_q)
          StIdle: begin
          end
          StFill: begin
            cnt_q <= cnt_q + AW'(1);
            if (cnt_q + AW'(1) == pretrig_q) begin
              state_q <= StWait;
            end
          end
          StWait: begin
            if (fire) begin
              trig_addr_q <= wr_ptr_q;
              if (remain == '0) begin
                state_q      <= StIdle;
                done_q       <= 1'b1;
                start_addr_q <= wr_ptr_q + AW'(1);
              end else begin
                cnt_q   <= remain;
                state_q <= StPost;
              end
            end
          end
          StPost: begin
            cnt_q <= cnt_q - AW'(1);
            if (cnt_q == AW'(1)) begin
              state_q      <= StIdle;
              done_q       <= 1'b1;
              start_addr_q <= wr_ptr_q + AW'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign state_o      = state_q;
  assign done_o       = done_q;
  assign trig_addr_o  = trig_addr_q;
  assign start_addr_o = start_addr_q;
  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core with DEPTH=16 and a free-running counter as probe data.
module tb_la_capture_core;

  localparam int unsigned DW = 16;
  localparam int unsigned DP = 16;
  localparam int unsigned TN = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data = '0;
  logic [TN-1:0] trig = '0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [TN-1:0] mask = '0;
  logic [TN-1:0] edg = '0;
  logic          mode = 1'b0;
  logic [3:0]    pretrig = '0;
  logic [1:0]    state;
  logic          done;
  logic [3:0]    trig_addr;
  logic [3:0]    start_addr;
  logic          rd_en = 1'b0;
  logic [3:0]    rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] d0;
  logic [DW-1:0] exp_d;

  la_capture_core #(.DATA_W(DW), .DEPTH(DP), .TRIG_N(TN)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .data_i      (data),
    .trig_i      (trig),
    .arm_i       (arm),
    .abort_i     (abort),
    .trig_mask_i (mask),
    .trig_edge_i (edg),
    .trig_mode_i (mode),
    .pretrig_i   (pretrig),
    .state_o     (state),
    .done_o      (done),
    .trig_addr_o (trig_addr),
    .start_addr_o(start_addr),
    .rd_en_i     (rd_en),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) data <= data + 16'd1;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Pulse arm; d0 is the sample value at the arm edge, so write k stores d0+k.
  task automatic do_arm(input logic [3:0] pre, input logic [3:0] m, input logic [3:0] e,
                        input logic md);
    pretrig = pre;
    mask    = m;
    edg     = e;
    mode    = md;
    arm     = 1'b1;
    d0      = data;
    step();
    arm     = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step();
    step();
    checks += 6;
    if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    if (trig_addr !== 4'd0) begin failures++; $display("FAIL reset_trig_addr got=%0d exp=0", trig_addr); end
    if (start_addr !== 4'd0) begin failures++; $display("FAIL reset_start got=%0d exp=0", start_addr); end
    if (rd_data !== 16'd0) begin failures++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data); end
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_forced;
    trig = '0;
    do_arm(4'd4, 4'b0000, 4'b0000, 1'b0);
    checks++;
    if (state !== 2'd1) begin failures++; $display("FAIL forced_fill got=%0d exp=1", state); end
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 4) begin
        checks++;
        if (state !== 2'd2) begin failures++; $display("FAIL forced_wait got=%0d exp=2", state); end
      end
      if (c == 5) begin
        checks++;
        if (state !== 2'd3) begin failures++; $display("FAIL forced_post got=%0d exp=3", state); end
      end
      if (c == 15) begin
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL forced_done_early got=%0b exp=0", done); end
      end
    end
    checks += 4;
    if (done !== 1'b1) begin failures++; $display("FAIL forced_done got=%0b exp=1", done); end
    if (state !== 2'd0) begin failures++; $display("FAIL forced_idle got=%0d exp=0", state); end
    if (trig_addr !== 4'd4) begin failures++; $display("FAIL forced_trig_addr got=%0d exp=4", trig_addr); end
    if (start_addr !== 4'd0) begin failures++; $display("FAIL forced_start got=%0d exp=0", start_addr); end
    for (int i = 0; i < 16; i++) begin
      rd_en   = 1'b1;
      rd_addr = 4'(i);
      step();
      rd_en = 1'b0;
      exp_d = d0 + 16'(i + 1);
      checks += 2;
      if (rd_valid !== 1'b1) begin failures++; $display("FAIL forced_rd_valid[%0d] got=%0b exp=1", i, rd_valid); end
      if (rd_data !== exp_d) begin failures++; $display("FAIL forced_rd[%0d] got=%0h exp=%0h", i, rd_data, exp_d); end
    end
  endtask

  task automatic test_edge_level;
    trig = 4'b0100;
    do_arm(4'd8, 4'b0100, 4'b0100, 1'b0);
    for (int c = 1; c <= 21; c++) begin
      trig[2] = (c != 13);
      step();
      if (c == 12 || c == 13) begin
        checks++;
        if (state !== 2'd2) begin failures++; $display("FAIL edge_no_fire_c%0d got=%0d exp=2", c, state); end
      end
      if (c == 14) begin
        checks++;
        if (state !== 2'd3) begin failures++; $display("FAIL edge_fire got=%0d exp=3", state); end
      end
    end
    checks += 3;
    if (done !== 1'b1) begin failures++; $display("FAIL edge_done got=%0b exp=1", done); end
    if (trig_addr !== 4'd13) begin failures++; $display("FAIL edge_trig_addr got=%0d exp=13", trig_addr); end
    if (start_addr !== 4'd5) begin failures++; $display("FAIL edge_start got=%0d exp=5", start_addr); end
    rd_en = 1'b1; rd_addr = 4'd13; step(); rd_en = 1'b0;
    exp_d = d0 + 16'd14;
    checks++;
    if (rd_data !== exp_d) begin failures++; $display("FAIL edge_trig_sample got=%0h exp=%0h", rd_data, exp_d); end
    rd_en = 1'b1; rd_addr = 4'd5; step(); rd_en = 1'b0;
    exp_d = d0 + 16'd6;
    checks++;
    if (rd_data !== exp_d) begin failures++; $display("FAIL edge_oldest got=%0h exp=%0h", rd_data, exp_d); end
    trig = '0;
  endtask

  task automatic test_and_mode;
    trig = '0;
    do_arm(4'd2, 4'b0011, 4'b0000, 1'b1);
    for (int c = 1; c <= 25; c++) begin
      trig[0] = (c >= 3);
      trig[1] = (c >= 12);
      step();
      if (c == 11) begin
        checks++;
        if (state !== 2'd2) begin failures++; $display("FAIL and_no_fire got=%0d exp=2", state); end
      end
      if (c == 12) begin
        checks++;
        if (state !== 2'd3) begin failures++; $display("FAIL and_fire got=%0d exp=3", state); end
      end
      if (c == 24) begin
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL and_done_early got=%0b exp=0", done); end
      end
    end
    checks += 3;
    if (done !== 1'b1) begin failures++; $display("FAIL and_done got=%0b exp=1", done); end
    if (trig_addr !== 4'd11) begin failures++; $display("FAIL and_trig_addr got=%0d exp=11", trig_addr); end
    if (start_addr !== 4'd9) begin failures++; $display("FAIL and_start got=%0d exp=9", start_addr); end
    rd_en = 1'b1; rd_addr = 4'd11; step(); rd_en = 1'b0;
    exp_d = d0 + 16'd12;
    checks++;
    if (rd_data !== exp_d) begin failures++; $display("FAIL and_trig_sample got=%0h exp=%0h", rd_data, exp_d); end
    trig = '0;
  endtask

  task automatic test_fill_ignore;
    trig = '0;
    do_arm(4'd8, 4'b0001, 4'b0001, 1'b0);
    for (int c = 1; c <= 27; c++) begin
      trig[0] = (c == 3 || c == 20);
      step();
      if (c == 19) begin
        checks++;
        if (state !== 2'd2) begin failures++; $display("FAIL fill_ignore_wait got=%0d exp=2", state); end
      end
      if (c == 20) begin
        checks++;
        if (state !== 2'd3) begin failures++; $display("FAIL fill_ignore_fire got=%0d exp=3", state); end
      end
    end
    checks += 3;
    if (done !== 1'b1) begin failures++; $display("FAIL fill_ignore_done got=%0b exp=1", done); end
    if (trig_addr !== 4'd3) begin failures++; $display("FAIL fill_ignore_trig_addr got=%0d exp=3", trig_addr); end
    if (start_addr !== 4'd11) begin failures++; $display("FAIL fill_ignore_start got=%0d exp=11", start_addr); end
    rd_en = 1'b1; rd_addr = 4'd3; step(); rd_en = 1'b0;
    exp_d = d0 + 16'd20;
    checks++;
    if (rd_data !== exp_d) begin failures++; $display("FAIL fill_ignore_sample got=%0h exp=%0h", rd_data, exp_d); end
    trig = '0;
  endtask

  task automatic test_boundaries;
    // pretrig = 15: no post-trigger samples
    do_arm(4'd15, 4'b0000, 4'b0000, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 15) begin
        checks += 2;
        if (state !== 2'd2) begin failures++; $display("FAIL pre15_wait got=%0d exp=2", state); end
        if (done !== 1'b0) begin failures++; $display("FAIL pre15_done_early got=%0b exp=0", done); end
      end
    end
    checks += 4;
    if (done !== 1'b1) begin failures++; $display("FAIL pre15_done got=%0b exp=1", done); end
    if (state !== 2'd0) begin failures++; $display("FAIL pre15_idle got=%0d exp=0", state); end
    if (trig_addr !== 4'd15) begin failures++; $display("FAIL pre15_trig_addr got=%0d exp=15", trig_addr); end
    if (start_addr !== 4'd0) begin failures++; $display("FAIL pre15_start got=%0d exp=0", start_addr); end

    // abort mid-POST
    do_arm(4'd4, 4'b0000, 4'b0000, 1'b0);
    for (int c = 1; c <= 8; c++) step();
    checks++;
    if (state !== 2'd3) begin failures++; $display("FAIL abort_pre_post got=%0d exp=3", state); end
    abort = 1'b1; step(); abort = 1'b0;
    checks += 2;
    if (state !== 2'd0) begin failures++; $display("FAIL abort_state got=%0d exp=0", state); end
    if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%0b exp=0", done); end
    for (int c = 0; c < 10; c++) step();
    checks += 2;
    if (state !== 2'd0) begin failures++; $display("FAIL abort_state_hold got=%0d exp=0", state); end
    if (done !== 1'b0) begin failures++; $display("FAIL abort_done_hold got=%0b exp=0", done); end

    // normal capture after abort
    do_arm(4'd4, 4'b0000, 4'b0000, 1'b0);
    for (int c = 1; c <= 16; c++) step();
    checks += 3;
    if (done !== 1'b1) begin failures++; $display("FAIL rearm_done got=%0b exp=1", done); end
    if (trig_addr !== 4'd4) begin failures++; $display("FAIL rearm_trig_addr got=%0d exp=4", trig_addr); end
    if (start_addr !== 4'd0) begin failures++; $display("FAIL rearm_start got=%0d exp=0", start_addr); end

    // arm and abort together
    do_arm(4'd4, 4'b0000, 4'b0000, 1'b0);
    step();
    step();
    arm = 1'b1; abort = 1'b1; step(); arm = 1'b0; abort = 1'b0;
    checks += 2;
    if (state !== 2'd0) begin failures++; $display("FAIL arm_abort_state got=%0d exp=0", state); end
    if (done !== 1'b0) begin failures++; $display("FAIL arm_abort_done got=%0b exp=0", done); end
  endtask

  task automatic test_reset_mid_wait;
    do_arm(4'd4, 4'b0000, 4'b0000, 1'b0);
    for (int c = 1; c <= 16; c++) step();
    // trig_addr/start_addr now 4/0; rerun with a trigger that never fires
    do_arm(4'd2, 4'b0001, 4'b0000, 1'b0);
    trig = '0;
    for (int c = 1; c <= 5; c++) begin
      rd_en   = (c == 5);
      rd_addr = 4'd0;
      step();
    end
    rd_en = 1'b0;
    exp_d = d0 + 16'd1;
    checks += 3;
    if (state !== 2'd2) begin failures++; $display("FAIL rst_pre_wait got=%0d exp=2", state); end
    if (rd_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_rd_valid got=%0b exp=1", rd_valid); end
    if (rd_data !== exp_d) begin failures++; $display("FAIL rst_pre_rd_data got=%0h exp=%0h", rd_data, exp_d); end
    #2 rst_n = 1'b0;
    #1;
    checks += 6;
    if (state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
    if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", done); end
    if (trig_addr !== 4'd0) begin failures++; $display("FAIL rst_trig_addr got=%0d exp=0", trig_addr); end
    if (start_addr !== 4'd0) begin failures++; $display("FAIL rst_start got=%0d exp=0", start_addr); end
    if (rd_data !== 16'd0) begin failures++; $display("FAIL rst_rd_data got=%0h exp=0", rd_data); end
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_rd_valid got=%0b exp=0", rd_valid); end
    step();
    rst_n = 1'b1;
    step();
    rd_en = 1'b1; rd_addr = 4'd0; step(); rd_en = 1'b0;
    checks += 2;
    if (rd_valid !== 1'b1) begin failures++; $display("FAIL post_rst_rd_valid got=%0b exp=1", rd_valid); end
    if (rd_data !== exp_d) begin failures++; $display("FAIL post_rst_rd_data got=%0h exp=%0h", rd_data, exp_d); end
    step();
    checks++;
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL post_rst_rd_valid_drop got=%0b exp=0", rd_valid); end
  endtask

  initial begin
    test_reset();
    test_forced();
    test_edge_level();
    test_and_mode();
    test_fill_ignore();
    test_boundaries();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
